alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Front-end controller for the 8-bit multi-cycle ALU (BEGIN / op_code / inbus / outbus / END interface).
- Accepts whole operations (opcode plus two operands) from a requester over a valid/ready handshake, then drives the ALU through start, operand load, completion wait and result collection.
- Returns a 16-bit result, or an error flag if the ALU never signals completion.
- Sits between the system bus / testbench driver and the ALU instance; owns all ALU control inputs.

Parameters:
- TIMEOUT, 64: maximum number of WAIT cycles for END before the operation is aborted. Legal range 2..65535.
- TW, $clog2(TIMEOUT+1): width of the timeout counter. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div
- req_x  in  8  first operand
- req_y  in  8  second operand
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result
- res_data  out  16  result
- res_err  out  1  result produced by timeout abort
- busy  out  1  high in every state except IDLE
- alu_begin  out  1  to ALU BEGIN
- alu_op  out  2  to ALU op_code
- alu_inbus  out  8  to ALU inbus
- alu_rst  out  1  ALU reset request, OR-ed externally with reset
- alu_outbus  in  8  from ALU outbus
- alu_end  in  1  from ALU END

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE; req_ready = 1; res_valid = 0; res_data = 0; res_err = 0; busy = 0.
  - alu_begin = 0; alu_op = 0; alu_inbus = 0; alu_rst = 0.
  - Reset asserted in any state, including mid-operation, forces all of the above on the next edge. The in-flight operation is discarded and no result is produced.
- Request capture:
  - Handshake occurs when req_valid & req_ready on a clock edge.
  - op, x and y are latched into internal registers on that edge.
  - req_ready = 1 only in IDLE.
- States (registered, one transition per clock):
  - IDLE: wait for handshake, then go to START.
  - START: alu_begin = 1; alu_inbus = x; alu_op = latched op. Next state LOAD_Y.
  - LOAD_Y: alu_begin = 0; alu_inbus = y. Timeout counter cleared. Next state WAIT.
  - WAIT: alu_inbus = 0; counter increments each cycle.
    - If alu_end = 1 and op ∈ {10,11}: capture alu_outbus into res_data[15:8], go to CAP_LO.
    - If alu_end = 1 and op ∈ {00,01}: res_data = {8'h00, alu_outbus}, res_err = 0, go to RESP.
    - Else if counter == TIMEOUT-1: res_data = 0, res_err = 1, alu_rst = 1 for exactly the next cycle, go to RESP.
  - CAP_LO: capture alu_outbus into res_data[7:0]; res_err = 0. Next state RESP. alu_end is not checked in this state.
  - RESP: res_valid = 1; res_data and res_err held stable. On res_ready = 1, clear res_valid and go to IDLE.
- Additional rules:
  - alu_op is held at the latched op from START through CAP_LO.
  - alu_end is ignored outside WAIT.
  - If alu_end and the timeout coincide in the same cycle, alu_end wins (no error).
- Latency:
  - Handshake edge to alu_begin high: 1 cycle.
  - Best case (alu_end in the first WAIT cycle, res_ready held high): handshake to res_valid is 4 cycles for add/sub, 5 cycles for mul/div.
- Throughput: one operation outstanding. req_ready is low from START until the edge after the RESP handshake.
- alu_rst:
  - Single-cycle pulse, asserted only following a timeout.
  - Registered output: high during the first RESP cycle.

Test Plan:
- Add: after reset, req op=00, x=8'h12, y=8'h34; ALU model asserts END with outbus=8'h46 on the 3rd WAIT cycle -> alu_begin high exactly 1 cycle with inbus=12, next cycle inbus=34; res_valid with res_data=16'h0046, res_err=0; busy low after the res_ready handshake.
- Multiply: op=10, x=8'h0F, y=8'h11; END with outbus=8'h00, next cycle outbus=8'hFF -> res_data=16'h00FF; alu_op=10 held through CAP_LO.
- Timeout: TIMEOUT=8, op=11, END never asserted -> exactly 8 WAIT cycles, res_err=1, res_data=0, alu_rst pulses exactly 1 cycle; next request completes normally.
- Backpressure: res_ready low for 5 cycles -> res_valid and res_data stable; req_valid held high meanwhile is not accepted (req_ready=0); accepted on the cycle after the RESP handshake.
- Reset mid-operation: reset asserted in WAIT -> next edge IDLE, all outputs at reset values; a later END pulse produces no res_valid.
- Coincidence and stray END: END asserted during START and LOAD_Y is ignored; END in the same cycle the counter reaches TIMEOUT-1 -> res_err=0, result captured.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for the 8-bit multi-cycle ALU: accepts one whole operation over
// valid/ready, walks the ALU through BEGIN/operand load/END wait and returns a 16-bit result.
module alu_op_sequencer #(
   parameter int TIMEOUT = 64,
   parameter int TW      = $clog2(TIMEOUT + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [7:0]  req_x,
   input  logic [7:0]  req_y,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic        res_err,
   output logic        busy,
   output logic        alu_begin,
   output logic [1:0]  alu_op,
   output logic [7:0]  alu_inbus,
   output logic        alu_rst,
   input  logic [7:0]  alu_outbus,
   input  logic        alu_end
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_LOAD_Y,
      S_WAIT,
      S_CAP_LO,
      S_RESP
   } state_t;

   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

   state_t        state;
   logic [1:0]    op_q;
   logic [7:0]    y_q;
   logic [TW-1:0] cnt;

   // NOTE: every output is a register written with <= in this one clocked block, so the
   // ALU sees glitch-free controls and no combinational path exists from req_* to alu_*.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         op_q      <= 2'b00;
         y_q       <= 8'h00;
         cnt       <= '0;
         req_ready <= 1'b1;
         res_valid <= 1'b0;
         res_data  <= 16'h0000;
         res_err   <= 1'b0;
         busy      <= 1'b0;
         alu_begin <= 1'b0;
         alu_op    <= 2'b00;
         alu_inbus <= 8'h00;
         alu_rst   <= 1'b0;
      end else begin
         alu_rst <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  op_q      <= req_op;
                  y_q       <= req_y;
                  alu_op    <= req_op;
                  alu_inbus <= req_x;
                  alu_begin <= 1'b1;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_START;
               end
            end
            S_START: begin
               alu_begin <= 1'b0;
               alu_inbus <= y_q;
               cnt       <= '0;
               state     <= S_LOAD_Y;
            end
            S_LOAD_Y: begin
               alu_inbus <= 8'h00;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               // END is tested before the timeout so a same-cycle completion is never an error
               if (alu_end) begin
                  if (op_q[1]) begin
                     res_data[15:8] <= alu_outbus;
                     state          <= S_CAP_LO;
                  end else begin
                     res_data  <= {8'h00, alu_outbus};
                     res_err   <= 1'b0;
                     res_valid <= 1'b1;
                     state     <= S_RESP;
                  end
               end else if (cnt == CNT_LAST) begin
                  res_data  <= 16'h0000;
                  res_err   <= 1'b1;
                  alu_rst   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= S_RESP;
               end
            end
            S_CAP_LO: begin
               res_data[7:0] <= alu_outbus;
               res_err       <= 1'b0;
               res_valid     <= 1'b1;
               state         <= S_RESP;
            end
            S_RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
